// File: rtl/xdma_udp_pkg.sv
// Shared definitions for the UDP/CMAC <-> XDMA stream glue.
// Holds default AXIS widths, the C2H arbiter state encoding, the source
// port index type and the round-robin grant helper.
package xdma_udp_pkg;

  localparam int unsigned XDMA_AXIS_TDATA_WIDTH = 512;
  localparam int unsigned XDMA_AXIS_TKEEP_WIDTH = 64;
  localparam int unsigned XDMA_AXIS_TUSER_WIDTH = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef logic port_idx_t;

  // Round-robin pick: on contention the port that was not served last wins.
  function automatic port_idx_t next_grant(input logic v0, input logic v1,
                                           input port_idx_t last_served);
    if (v0 && v1) begin
      return port_idx_t'(~last_served);
    end
    return port_idx_t'(v1);
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// axis_skid_reg: 2-entry registered AXI-Stream slice.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   s_valid, s_data  upstream beat; accepted when s_valid && s_ready
//   s_ready          registered "occupancy < 2"
//   s_ready_nxt_c    next-cycle value of s_ready (combinational), so a caller
//                    can register its own per-source ready in step with it
//   m_valid, m_data  registered head entry
//   m_ready          downstream accept
// Output data is held stable while m_valid && !m_ready. No combinational
// path from m_ready to s_ready.
module axis_skid_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             s_ready_nxt_c,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
);

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             push, pop;

  // Head entry drives the output; tail catches the beat that arrives while
  // the head is stalled.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    push   = s_valid && ready_q;
    pop    = valid_q && m_ready;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = s_data;
        else               tail_d = s_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      // push needs occ<2 and pop needs occ>0, so occupancy is exactly 1
      2'b11:   head_d = s_data;
      default: ;
    endcase
    ready_d = (occ_d < 2'd2);
    valid_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign s_ready       = ready_q;
  assign s_ready_nxt_c = ready_d;
  assign m_valid       = valid_q;
  assign m_data        = head_q;

endmodule

// File: rtl/xdma_c2h_stream_arbiter.sv
// xdma_c2h_stream_arbiter: packet-granular round-robin merge of two AXIS RX
// paths (qsfp1 -> s0, qsfp2 -> s1) into the XDMA C2H stream.
// Ports:
//   xdma_clk, xdma_reset      clock, synchronous active-low reset
//   s0_axis_*, s1_axis_*      source streams (tvalid/tready/tlast/tdata/tkeep/tuser)
//   m_axis_*                  merged stream; m_axis_tuser = {src_idx, s_tuser}
//   pkt_cnt0/pkt_cnt1/stall_cnt  statistics, present only with
//                                XDMA_C2H_ARB_STATS_EN defined
// A grant is held for a whole packet; one IDLE decision cycle per packet.
module xdma_c2h_stream_arbiter
  import xdma_udp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XDMA_AXIS_TDATA_WIDTH,
  parameter int unsigned KEEP_WIDTH = XDMA_AXIS_TKEEP_WIDTH,
  parameter int unsigned USER_WIDTH = XDMA_AXIS_TUSER_WIDTH
) (
  input  logic                  xdma_clk,
  input  logic                  xdma_reset,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic                  s0_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic [USER_WIDTH-1:0] s0_axis_tuser,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  input  logic                  s1_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic [USER_WIDTH-1:0] s1_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [USER_WIDTH:0]   m_axis_tuser
`ifdef XDMA_C2H_ARB_STATS_EN
  ,
  output logic [31:0]           pkt_cnt0,
  output logic [31:0]           pkt_cnt1,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int unsigned PAYLOAD_W = (USER_WIDTH + 1) + 1 + KEEP_WIDTH + DATA_WIDTH;

  arb_state_t state_q, state_d;
  port_idx_t  grant_q, grant_d;
  port_idx_t  last_q, last_d;
  logic       s0_tready_q, s0_tready_d;
  logic       s1_tready_q, s1_tready_d;

  logic                 acc0, acc1, acc_last;
  logic                 skid_ready, skid_ready_nxt, skid_push;
  logic [PAYLOAD_W-1:0] skid_in, skid_out;

  // Source readies are flops, so a handshake is simply valid && ready.
  assign acc0     = s0_axis_tvalid && s0_tready_q;
  assign acc1     = s1_axis_tvalid && s1_tready_q;
  assign acc_last = grant_q ? (acc1 && s1_axis_tlast) : (acc0 && s0_axis_tlast);

  // Next state, grant and per-source readies.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          state_d = BUSY;
          grant_d = next_grant(s0_axis_tvalid, s1_axis_tvalid, last_q);
        end
      end
      BUSY: begin
        if (acc_last) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered against next-cycle skid room so no beat can overrun the slice.
    s0_tready_d = (state_d == BUSY) && (grant_d == 1'b0) && skid_ready_nxt;
    s1_tready_d = (state_d == BUSY) && (grant_d == 1'b1) && skid_ready_nxt;
  end

  always_ff @(posedge xdma_clk) begin
    if (!xdma_reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      s0_tready_q <= 1'b0;
      s1_tready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      s0_tready_q <= s0_tready_d;
      s1_tready_q <= s1_tready_d;
    end
  end

  assign s0_axis_tready = s0_tready_q;
  assign s1_axis_tready = s1_tready_q;

  // Beat forwarded unmodified, tagged with its source port.
  assign skid_push = (acc0 || acc1) && skid_ready;
  assign skid_in   = grant_q ? {grant_q, s1_axis_tuser, s1_axis_tlast, s1_axis_tkeep, s1_axis_tdata}
                             : {grant_q, s0_axis_tuser, s0_axis_tlast, s0_axis_tkeep, s0_axis_tdata};

  axis_skid_reg #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk           (xdma_clk),
    .rst_n         (xdma_reset),
    .s_valid       (skid_push),
    .s_data        (skid_in),
    .s_ready       (skid_ready),
    .s_ready_nxt_c (skid_ready_nxt),
    .m_valid       (m_axis_tvalid),
    .m_data        (skid_out),
    .m_ready       (m_axis_tready)
  );

  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = skid_out;

`ifdef XDMA_C2H_ARB_STATS_EN
  logic [31:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [31:0] pkt_cnt1_q, pkt_cnt1_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Free-running wrap-around counters.
  always_comb begin
    pkt_cnt0_d  = pkt_cnt0_q;
    pkt_cnt1_d  = pkt_cnt1_q;
    stall_cnt_d = stall_cnt_q;
    if (acc0 && s0_axis_tlast)           pkt_cnt0_d  = pkt_cnt0_q + 32'd1;
    if (acc1 && s1_axis_tlast)           pkt_cnt1_d  = pkt_cnt1_q + 32'd1;
    if (m_axis_tvalid && !m_axis_tready) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge xdma_clk) begin
    if (!xdma_reset) begin
      pkt_cnt0_q  <= 32'd0;
      pkt_cnt1_q  <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      pkt_cnt0_q  <= pkt_cnt0_d;
      pkt_cnt1_q  <= pkt_cnt1_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pkt_cnt0  = pkt_cnt0_q;
  assign pkt_cnt1  = pkt_cnt1_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_xdma_c2h_stream_arbiter.sv
// Scoreboard bench for xdma_c2h_stream_arbiter. Expected beats are queued in
// hand-derived arbitration order; a negedge monitor pops and compares every
// transferred output beat and checks payload stability while stalled.
module tb_xdma_c2h_stream_arbiter;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = 64;
  localparam int unsigned UW = 1;

  typedef struct packed {
    logic [UW:0]   user;
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          xdma_reset;
  logic          s0_tvalid, s0_tready, s0_tlast;
  logic [DW-1:0] s0_tdata;
  logic [KW-1:0] s0_tkeep;
  logic [UW-1:0] s0_tuser;
  logic          s1_tvalid, s1_tready, s1_tlast;
  logic [DW-1:0] s1_tdata;
  logic [KW-1:0] s1_tkeep;
  logic [UW-1:0] s1_tuser;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW:0]   m_tuser;
`ifdef XDMA_C2H_ARB_STATS_EN
  logic [31:0]   pkt_cnt0, pkt_cnt1, stall_cnt;
`endif

  always #5 clk = ~clk;

  xdma_c2h_stream_arbiter dut (
    .xdma_clk       (clk),
    .xdma_reset     (xdma_reset),
    .s0_axis_tvalid (s0_tvalid),
    .s0_axis_tready (s0_tready),
    .s0_axis_tlast  (s0_tlast),
    .s0_axis_tdata  (s0_tdata),
    .s0_axis_tkeep  (s0_tkeep),
    .s0_axis_tuser  (s0_tuser),
    .s1_axis_tvalid (s1_tvalid),
    .s1_axis_tready (s1_tready),
    .s1_axis_tlast  (s1_tlast),
    .s1_axis_tdata  (s1_tdata),
    .s1_axis_tkeep  (s1_tkeep),
    .s1_axis_tuser  (s1_tuser),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tlast   (m_tlast),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tuser   (m_tuser)
`ifdef XDMA_C2H_ARB_STATS_EN
    ,
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1),
    .stall_cnt      (stall_cnt)
`endif
  );

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    acc_cnt[2];
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic beat_t mk_beat(input int port, input int id, input int i, input int n,
                                    input logic [KW-1:0] lk, input logic usr);
    beat_t       b;
    logic [31:0] w;
    w      = 32'(id + i);
    b.data = {16{w}};
    b.keep = (i == n - 1) ? lk : '1;
    b.last = (i == n - 1);
    b.user = {1'(port), usr};
    return b;
  endfunction

  task automatic push_pkt(input int port, input int id, input int n,
                          input logic [KW-1:0] lk, input logic usr);
    for (int i = 0; i < n; i++) exp_q.push_back(mk_beat(port, id, i, n, lk, usr));
  endtask

  task automatic drive(input int port, input logic v, input beat_t b);
    if (port == 0) begin
      s0_tvalid = v; s0_tdata = b.data; s0_tkeep = b.keep; s0_tlast = b.last; s0_tuser = b.user[0];
    end else begin
      s1_tvalid = v; s1_tdata = b.data; s1_tkeep = b.keep; s1_tlast = b.last; s1_tuser = b.user[0];
    end
  endtask

  // Called at posedge+1; the tready seen now is what the next edge samples.
  task automatic send_pkt(input int port, input int id, input int n, input logic [KW-1:0] lk,
                          input logic usr, input int gap, input bit chk_lat);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      int    waited;
      logic  rdy;
      b      = mk_beat(port, id, i, n, lk, usr);
      waited = 0;
      drive(port, 1'b1, b);
      do begin
        rdy = (port == 0) ? s0_tready : s1_tready;
        @(posedge clk); #1;
        waited++;
      end while (!rdy && waited < 200);
      if (!rdy) begin
        check("handshake_timeout", 640'(rdy), 640'(1));
        drive(port, 1'b0, b);
        return;
      end
      acc_cnt[port]++;
      if (chk_lat) begin
        check("latency_valid", 640'(m_tvalid), 640'(1));
        check("latency_data", 640'(m_tdata), 640'(b.data));
      end
      if (i == 0 && gap > 0) begin
        drive(port, 1'b0, b);
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    drive(port, 1'b0, mk_beat(port, id, 0, 1, '0, 1'b0));
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin @(posedge clk); #1; c++; end
    check("scoreboard_drained", 640'(exp_q.size()), 640'(0));
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Output monitor: compare transferred beats, hold payload while stalled.
  beat_t cur, held, e;
  bit    stalled = 1'b0;
  always @(negedge clk) begin
    cur = '{user: m_tuser, last: m_tlast, keep: m_tkeep, data: m_tdata};
    if (!xdma_reset) begin
      stalled = 1'b0;
    end else if (m_tvalid) begin
      if (stalled) check("stable_payload", 640'(cur), 640'(held));
      if (m_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %0h expected no beat", cur);
        end else begin
          e = exp_q.pop_front();
          check("out_beat", 640'(cur), 640'(e));
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = cur;
      end
    end else begin
      if (stalled) check("valid_held", 640'(m_tvalid), 640'(1));
      stalled = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, elapsed, base, s1_seen;
    bit s0_done;
    xdma_reset = 1'b0;
    m_tready   = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 640'(m_tvalid), 640'(0));
    check("rst_m_tlast", 640'(m_tlast), 640'(0));
    check("rst_m_tdata", 640'(m_tdata), 640'(0));
    check("rst_m_tkeep", 640'(m_tkeep), 640'(0));
    check("rst_m_tuser", 640'(m_tuser), 640'(0));
    check("rst_s0_tready", 640'(s0_tready), 640'(0));
    check("rst_s1_tready", 640'(s1_tready), 640'(0));
    xdma_reset = 1'b1;
    m_tready   = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("idle_s0_tready", 640'(s0_tready), 640'(0));
    check("idle_s1_tready", 640'(s1_tready), 640'(0));

    // Both ports continuously busy: s0,s1,s0,s1; 4 x (1 bubble + 2 beats) = 12 cycles
    push_pkt(0, 'h200, 2, 64'h0, 1'b0);
    push_pkt(1, 'h300, 2, 64'hFFFF, 1'b1);
    push_pkt(0, 'h210, 2, 64'h1, 1'b1);
    push_pkt(1, 'h310, 2, 64'h8000_0000_0000_0000, 1'b0);
    start = cyc;
    fork
      begin
        send_pkt(0, 'h200, 2, 64'h0, 1'b0, 0, 1'b0);
        send_pkt(0, 'h210, 2, 64'h1, 1'b1, 0, 1'b0);
      end
      begin
        send_pkt(1, 'h300, 2, 64'hFFFF, 1'b1, 0, 1'b0);
        send_pkt(1, 'h310, 2, 64'h8000_0000_0000_0000, 1'b0, 0, 1'b0);
      end
    join
    elapsed = cyc - start;
    check("rr_cycles", 640'(elapsed), 640'(12));
    wait_drain();

    // s0 alone, 3 beats, last keep 0x0F, 1-cycle latency per accepted beat
    push_pkt(0, 'h100, 3, 64'h0F, 1'b1);
    send_pkt(0, 'h100, 3, 64'h0F, 1'b1, 0, 1'b1);
    wait_drain();

    // s0 drops tvalid mid-packet; s1 must stay blocked until s0 tlast
    push_pkt(0, 'h400, 3, 64'h7, 1'b1);
    push_pkt(1, 'h410, 2, '1, 1'b0);
    s0_done = 1'b0;
    s1_seen = 0;
    fork
      begin
        send_pkt(0, 'h400, 3, 64'h7, 1'b1, 5, 1'b0);
        s0_done = 1'b1;
      end
      begin
        @(posedge clk); #1;
        send_pkt(1, 'h410, 2, '1, 1'b0, 0, 1'b0);
      end
      begin
        while (!s0_done) begin
          @(negedge clk);
          if (s1_tready) s1_seen++;
        end
      end
    join
    check("s1_blocked_mid_pkt", 640'(s1_seen), 640'(0));
    wait_drain();

    // Output stalled 10 cycles: only two beats buffered, s0 backpressured
    push_pkt(0, 'h500, 6, 64'h3, 1'b0);
    m_tready = 1'b0;
    base     = acc_cnt[0];
    fork
      send_pkt(0, 'h500, 6, 64'h3, 1'b0, 0, 1'b0);
      begin
        repeat (10) begin @(posedge clk); #1; end
        check("stall_buffered", 640'(acc_cnt[0] - base), 640'(2));
        check("stall_s0_tready", 640'(s0_tready), 640'(0));
        m_tready = 1'b1;
      end
    join
    wait_drain();

`ifdef XDMA_C2H_ARB_STATS_EN
    check("pkt_cnt0", 640'(pkt_cnt0), 640'(5));
    check("pkt_cnt1", 640'(pkt_cnt1), 640'(3));
`endif

    // Reset mid-packet (last served was s0): skid flushed, port 0 wins next
    m_tready = 1'b0;
    drive(0, 1'b1, mk_beat(0, 'h600, 0, 4, '1, 1'b0));
    repeat (2) begin @(posedge clk); #1; end
    drive(1, 1'b1, mk_beat(1, 'h700, 0, 1, 64'hF, 1'b0));
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_m_tvalid", 640'(m_tvalid), 640'(1));
    xdma_reset = 1'b0;
    @(posedge clk); #1;
    xdma_reset = 1'b1;
    check("post_rst_m_tvalid", 640'(m_tvalid), 640'(0));
    check("post_rst_s0_tready", 640'(s0_tready), 640'(0));
    check("post_rst_s1_tready", 640'(s1_tready), 640'(0));
    m_tready = 1'b1;
    push_pkt(0, 'h800, 1, 64'hFF, 1'b0);
    push_pkt(1, 'h700, 1, 64'hF, 1'b0);
    fork
      send_pkt(0, 'h800, 1, 64'hFF, 1'b0, 0, 1'b0);
      send_pkt(1, 'h700, 1, 64'hF, 1'b0, 0, 1'b0);
    join
    wait_drain();

`ifdef XDMA_C2H_ARB_STATS_EN
    check("pkt_cnt0_after_rst", 640'(pkt_cnt0), 640'(1));
    check("pkt_cnt1_after_rst", 640'(pkt_cnt1), 640'(1));
`endif

    check("final_queue_empty", 640'(exp_q.size()), 640'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
